// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered txd.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE;
    localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_div
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_nx;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh, sh_nx;
    logic          txd_q, txd_nx;
    logic          bit_end, last_stop, xfer;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    assign bit_end   = (div == DW'(CLKS_PER_BIT - 1));
    assign last_stop = (state == STOP) && bit_end && (bit_cnt == 3'(STOP_BITS - 1));
    assign xfer      = in_valid && in_ready;
    assign txd       = txd_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            txd_q <= txd_nx;
            if (state == IDLE || bit_end)
                div <= '0;
            else
                div <= div + 1'b1;
            // bit_cnt indexes data bits, wraps 7->0 on leaving DATA, then counts stop bits
            if (state == DATA && bit_end)
                bit_cnt <= bit_cnt + 3'd1;
            else if (state == STOP && bit_end)
                bit_cnt <= last_stop ? 3'd0 : bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (xfer)
                par_q <= (^in_data) ^ 1'(PARITY_ODD);
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (xfer) state_nx = START;
            START: if (bit_end) state_nx = DATA;
            DATA:
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_nx = STOP;
`endif
            STOP:  if (last_stop) state_nx = xfer ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || last_stop;
        busy     = (state != IDLE);
        done     = last_stop;
        sh_nx    = sh;
        if (state == DATA && bit_end)
            sh_nx = {1'b0, sh[7:1]};
        if (xfer)
            sh_nx = in_data;
        // txd is registered from the next state so the line changes on the bit boundary
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = sh_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_nx = par_q;
`endif
            default: txd_nx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (1 stop/even, 2 stop/odd), per-cycle
// frame checks driven from a queue of expected frames pushed at stimulus time.
module tb_uart_tx;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [11:0] bits;
        int          nb;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_valid, in_ready, txd, busy, done;
    exp_t            q0[$], q1[$];
    int              checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .resetn(resetn), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

    uart_tx #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .clk(clk), .resetn(resetn), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // expected line bits: start, data LSB first, optional parity, stop(s)
    task automatic push(input int i, input logic [7:0] b);
        exp_t e;
        int   sb  = (i == 0) ? 1 : 2;
        logic odd = (i == 1);
        e.nb      = 9 + PAR + sb;
        e.bits    = '1;
        e.bits[0] = 1'b0;
        e.bits[8:1] = b;
        if (PAR == 1) e.bits[9] = (^b) ^ odd;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drive(input int i, input logic [7:0] b);
        in_data[i]  = b;
        in_valid[i] = 1'b1;
        push(i, b);
    endtask

    // returns in the cycle after the accepting edge
    task automatic wait_accept(input int i);
        logic rdy;
        bit   ok = 0;
        int   n  = 0;
        while (!ok && n < 200) begin
            rdy = in_ready[i];
            @(posedge clk); #1;
            n++;
            ok = rdy;
        end
        chk($sformatf("u%0d accept", i), ok, 1);
    endtask

    task automatic check_frame(input int i, input int ncyc);
        exp_t e;
        int   f;
        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
        f = e.nb * N;
        for (int c = 1; c <= f && c <= ncyc; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (!in_valid[i]) in_data[i] = 8'($urandom);
            chk($sformatf("u%0d txd c%0d", i, c), txd[i], e.bits[(c-1)/N]);
            chk($sformatf("u%0d busy c%0d", i, c), busy[i], 1);
            chk($sformatf("u%0d done c%0d", i, c), done[i], c == f);
            chk($sformatf("u%0d in_ready c%0d", i, c), in_ready[i], c == f);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, " txd"}, txd[i], 1);
        chk({tag, " busy"}, busy[i], 0);
        chk({tag, " done"}, done[i], 0);
        chk({tag, " in_ready"}, in_ready[i], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        in_valid = '0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle(0, "reset u0");
        chk_idle(1, "reset u1");
        resetn = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk_idle(0, "idle u0");
            chk_idle(1, "idle u1");
        end

        // single frame 0xA5
        drive(0, 8'hA5);
        wait_accept(0);
        in_valid[0] = 1'b0;
        check_frame(0, 1000);
        @(posedge clk); #1;
        chk_idle(0, "after A5");

        // back-to-back 0x00 then 0xFF with in_valid held
        drive(0, 8'h00);
        wait_accept(0);
        in_data[0] = 8'hFF;
        push(0, 8'hFF);
        check_frame(0, 1000);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_frame(0, 1000);
        @(posedge clk); #1;
        chk_idle(0, "after b2b");

        // reset at t+18 of 0x3C; a request held through reset is only taken afterwards
        drive(0, 8'h3C);
        wait_accept(0);
        in_valid[0] = 1'b0;
        check_frame(0, 18);
        resetn = 1'b0;
        drive(0, 8'h3C);
        @(posedge clk); #1;
        chk_idle(0, "mid reset");
        resetn = 1'b1;
        wait_accept(0);
        in_valid[0] = 1'b0;
        check_frame(0, 1000);
        @(posedge clk); #1;
        chk_idle(0, "after 3C");

        // 0x07 on both instances (parity even / odd when enabled)
        drive(0, 8'h07);
        wait_accept(0);
        in_valid[0] = 1'b0;
        check_frame(0, 1000);
        drive(1, 8'h07);
        wait_accept(1);
        in_valid[1] = 1'b0;
        check_frame(1, 1000);
        @(posedge clk); #1;
        chk_idle(1, "after 07");

        // two stop bits, in_data scrambled during the frame
        drive(1, 8'h55);
        wait_accept(1);
        in_valid[1] = 1'b0;
        check_frame(1, 1000);
        @(posedge clk); #1;
        chk_idle(1, "after 55");
        chk_idle(0, "u0 end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
